// File: rtl/vdp1_cmd_seq.sv
// VDP1 command list sequencer: walks the command table chain in VRAM, resolves
// jump modes and hands each drawable command table to the draw engine.
//
// state | meaning
// IDLE  | list finished or never started
// HDR0  | reading word 0 (CMDCTRL)
// HDR1  | reading word 1 (CMDLINK)
// BODY  | reading words 2..15
// ISSUE | command presented, waiting for draw engine ack
// NEXT  | resolving the address of the next command table
module vdp1_cmd_seq #(
  parameter int VRAM_AW = 18
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  output logic [VRAM_AW-1:0] VRAM_A,
  output logic               VRAM_RD,
  input  logic [15:0]        VRAM_DI,
  input  logic               VRAM_RDY,
  output logic [255:0]       CMD,
  output logic               CMD_VALID,
  input  logic               CMD_ACK,
  output logic [VRAM_AW-1:0] CUR_ADDR,
  output logic [VRAM_AW-1:0] LAST_ADDR,
  output logic               CEF,
  output logic               BEF,
  output logic               BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_BODY,
    S_ISSUE,
    S_NEXT
  } state_t;

  state_t state, state_nxt;

  logic [15:0]        words [16];
  logic [3:0]         word_cnt;
  logic [VRAM_AW-1:0] cur_addr, last_addr, stack_addr;
  logic               stack_valid, cef, bef;
  logic [VRAM_AW-1:0] seq_addr, link_addr;
  logic [17:0]        link_full;
  logic [2:0]         jp;
  logic [3:0]         comm;
  logic               comm_ok, rd_done;

  assign jp        = words[0][14:12];
  assign comm      = words[0][3:0];
  assign rd_done   = VRAM_RD && VRAM_RDY;
  assign seq_addr  = cur_addr + VRAM_AW'(16);
  // CMDLINK is in 8-byte units; its low two bits are dropped to stay table-aligned
  assign link_full = {words[1][15:2], 4'b0000};
  assign link_addr = VRAM_AW'(link_full);

  always_comb begin
    comm_ok = 1'b0;
    case (comm)
      4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA: comm_ok = 1'b1;
      default: comm_ok = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (START) begin
      state_nxt = S_HDR0;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_IDLE;
        S_HDR0:  if (rd_done) state_nxt = VRAM_DI[15] ? S_IDLE : S_HDR1;
        S_HDR1:  if (rd_done) state_nxt = (jp[2] || !comm_ok) ? S_NEXT : S_BODY;
        S_BODY:  if (rd_done && word_cnt == 4'd15) state_nxt = S_ISSUE;
        S_ISSUE: if (CMD_ACK) state_nxt = S_NEXT;
        S_NEXT:  state_nxt = S_HDR0;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    VRAM_RD   = (state == S_HDR0) || (state == S_HDR1) || (state == S_BODY);
    VRAM_A    = cur_addr + VRAM_AW'(word_cnt);
    CMD_VALID = (state == S_ISSUE);
    BUSY      = (state != S_IDLE);
    CUR_ADDR  = cur_addr;
    LAST_ADDR = last_addr;
    CEF       = cef;
    BEF       = bef;
    CMD       = '0;
    for (int i = 0; i < 16; i++) CMD[255-16*i -: 16] = words[i];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      word_cnt    <= '0;
      cur_addr    <= '0;
      last_addr   <= '0;
      stack_addr  <= '0;
      stack_valid <= 1'b0;
      cef         <= 1'b0;
      bef         <= 1'b0;
      for (int i = 0; i < 16; i++) words[i] <= '0;
    end else if (START) begin
      // restart discards any in-flight read data or ack from this cycle
      bef         <= cef;
      cef         <= 1'b0;
      stack_valid <= 1'b0;
      cur_addr    <= '0;
      word_cnt    <= '0;
    end else begin
      case (state)
        S_HDR0, S_HDR1, S_BODY: begin
          if (rd_done) begin
            words[word_cnt] <= VRAM_DI;
            word_cnt        <= word_cnt + 4'd1;
            if (state == S_HDR0 && VRAM_DI[15]) begin
              cef       <= 1'b1;
              last_addr <= cur_addr;
            end
          end
        end
        S_NEXT: begin
          word_cnt <= '0;
          case (jp[1:0])
            2'd0: cur_addr <= seq_addr;
            2'd1: cur_addr <= link_addr;
            2'd2: begin
              stack_addr  <= seq_addr;
              stack_valid <= 1'b1;
              cur_addr    <= link_addr;
            end
            default: begin
              if (stack_valid) begin
                cur_addr    <= stack_addr;
                stack_valid <= 1'b0;
              end else begin
                cur_addr <= seq_addr;
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vdp1_cmd_seq.sv
// Bench for vdp1_cmd_seq: directed vector table, hand-written restart/call/wrap
// sequences, and random command chains checked against a list-walking model.
module tb_vdp1_cmd_seq;
  localparam int AW = 18;
  localparam int NW = 262144;

  logic          CLK = 1'b0;
  logic          RST, START, VRAM_RD, VRAM_RDY, CMD_VALID, CMD_ACK, CEF, BEF, BUSY;
  logic [AW-1:0] VRAM_A, CUR_ADDR, LAST_ADDR;
  logic [15:0]   VRAM_DI;
  logic [255:0]  CMD;

  vdp1_cmd_seq #(.VRAM_AW(AW)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .VRAM_A(VRAM_A), .VRAM_RD(VRAM_RD), .VRAM_DI(VRAM_DI), .VRAM_RDY(VRAM_RDY),
    .CMD(CMD), .CMD_VALID(CMD_VALID), .CMD_ACK(CMD_ACK),
    .CUR_ADDR(CUR_ADDR), .LAST_ADDR(LAST_ADDR), .CEF(CEF), .BEF(BEF), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  logic [15:0]  mem [NW];
  int           checks = 0;
  int           errors = 0;

  int           got_reads[$];
  logic [255:0] got_cmds[$];
  int           got_cmd_addr[$];
  int           exp_reads[$];
  logic [255:0] exp_cmds[$];
  int           exp_cmd_addr[$];
  int           exp_last;
  bit           timed_out;
  int           ack_gap, rdy_to_valid, start_rd, start_a;
  bit           patch_on = 1'b0;
  int           patch_addr = 0;

  typedef struct {
    string       name;
    logic [15:0] w0;
    logic [15:0] w1;
    int          n_reads;
    int          n_cmds;
    int          last;
  } vec_t;
  vec_t vecs[11];

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_cmd(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Every table slot in the low region ends the list unless overwritten.
  task automatic clear_mem();
    for (int s = 0; s < 128; s++)
      for (int j = 0; j < 16; j++)
        mem[s*16+j] = (j == 0) ? 16'h8000 : 16'($urandom);
  endtask

  function automatic bit comm_forwarded(input logic [15:0] w0);
    int c = int'(w0[3:0]);
    return !w0[14] && (c == 0 || c == 1 || c == 2 || c == 4 || c == 5 ||
                       c == 6 || c == 8 || c == 9 || c == 10);
  endfunction

  // Reference: walk the chain in VRAM image, listing every read and forwarded command.
  task automatic model();
    int a = 0, ret = 0, seq, tgt;
    bit ret_ok = 1'b0;
    logic [15:0] w0, w1;
    logic [255:0] c;
    exp_reads.delete(); exp_cmds.delete(); exp_cmd_addr.delete();
    exp_last = -1;
    for (int step = 0; step < 400; step++) begin
      w0 = mem[a];
      exp_reads.push_back(a);
      if (w0[15]) begin
        exp_last = a;
        return;
      end
      w1 = mem[(a + 1) % NW];
      exp_reads.push_back((a + 1) % NW);
      if (comm_forwarded(w0)) begin
        for (int j = 2; j < 16; j++) exp_reads.push_back((a + j) % NW);
        for (int j = 0; j < 16; j++) c[255-16*j -: 16] = mem[(a + j) % NW];
        exp_cmds.push_back(c);
        exp_cmd_addr.push_back(a);
      end
      seq = (a + 16) % NW;
      tgt = ((int'(w1) / 4) * 16) % NW;
      case (int'(w0[13:12]))
        0: a = seq;
        1: a = tgt;
        2: begin ret = seq; ret_ok = 1'b1; a = tgt; end
        default: begin
          if (ret_ok) begin a = ret; ret_ok = 1'b0; end
          else a = seq;
        end
      endcase
    end
  endtask

  // Acts as VRAM arbiter and draw engine with random latencies until BUSY drops.
  task automatic run_list(input bit do_start);
    int n = 0, rdy_wait, ack_wait = 0, last_rdy_n = 0, ack_n = 0;
    bit prev_valid = 1'b0, prev_rd = 1'b0, gap_pend = 1'b0;
    got_reads.delete(); got_cmds.delete(); got_cmd_addr.delete();
    ack_gap = -1; rdy_to_valid = -1; timed_out = 1'b0;
    if (do_start) begin
      @(negedge CLK); START = 1'b1;
      @(negedge CLK); START = 1'b0;
      start_rd = int'(VRAM_RD); start_a = int'(VRAM_A);
    end else begin
      @(negedge CLK);
    end
    rdy_wait = $urandom_range(0, 3);
    while (BUSY && n < 4000) begin
      VRAM_RDY = 1'b0; CMD_ACK = 1'b0;
      if (VRAM_RD && !prev_rd && gap_pend) begin
        ack_gap = n - ack_n; gap_pend = 1'b0;
      end
      if (CMD_VALID && !prev_valid) begin
        got_cmds.push_back(CMD);
        got_cmd_addr.push_back(int'(CUR_ADDR));
        rdy_to_valid = n - last_rdy_n;
        ack_wait = $urandom_range(0, 4);
        if (patch_on && int'(CUR_ADDR) == patch_addr) mem[0] = 16'h8000;
      end
      if (CMD_VALID) begin
        if (ack_wait == 0) begin
          CMD_ACK = 1'b1; ack_n = n; gap_pend = 1'b1;
        end else ack_wait--;
      end else if (VRAM_RD) begin
        if (rdy_wait == 0) begin
          VRAM_RDY = 1'b1;
          VRAM_DI = mem[int'(VRAM_A)];
          got_reads.push_back(int'(VRAM_A));
          last_rdy_n = n;
          rdy_wait = $urandom_range(0, 3);
        end else rdy_wait--;
      end
      prev_valid = CMD_VALID; prev_rd = VRAM_RD;
      @(negedge CLK); n++;
    end
    VRAM_RDY = 1'b0; CMD_ACK = 1'b0;
    timed_out = BUSY;
  endtask

  task automatic check_heads(input string name, input int exp[$]);
    int heads[$];
    foreach (got_reads[i]) if ((got_reads[i] & 15) == 0) heads.push_back(got_reads[i]);
    check_int({name, "_nheads"}, heads.size(), exp.size());
    foreach (exp[i]) if (i < heads.size()) check_int({name, "_head"}, heads[i], exp[i]);
  endtask

  initial begin
    int k, bad;
    logic [255:0] c;
    vecs[0]  = '{"poly",      16'h0004, 16'h0000, 17, 1, 'h10};
    vecs[1]  = '{"jump",      16'h1000, 16'h0010, 17, 1, 'h40};
    vecs[2]  = '{"skip",      16'h4000, 16'h0000,  3, 0, 'h10};
    vecs[3]  = '{"bad_comm3", 16'h0003, 16'h0000,  3, 0, 'h10};
    vecs[4]  = '{"comm_a",    16'h000A, 16'h0000, 17, 1, 'h10};
    vecs[5]  = '{"bad_commb", 16'h000B, 16'h0000,  3, 0, 'h10};
    vecs[6]  = '{"skip_jump", 16'h5000, 16'h0023,  3, 0, 'h80};
    vecs[7]  = '{"ret_empty", 16'h3000, 16'h0000, 17, 1, 'h10};
    vecs[8]  = '{"call",      16'h2000, 16'h0100, 17, 1, 'h400};
    vecs[9]  = '{"end_at_0",  16'h8000, 16'h0000,  1, 0, 'h0};
    vecs[10] = '{"jump_lsb",  16'h1001, 16'h000B, 17, 1, 'h20};

    RST = 1'b1; START = 1'b0; VRAM_DI = '0; VRAM_RDY = 1'b0; CMD_ACK = 1'b0;
    repeat (3) @(negedge CLK);
    check_int("rst_vram_a", int'(VRAM_A), 0);
    check_int("rst_vram_rd", int'(VRAM_RD), 0);
    check_cmd("rst_cmd", CMD, '0);
    check_int("rst_cmd_valid", int'(CMD_VALID), 0);
    check_int("rst_cur_addr", int'(CUR_ADDR), 0);
    check_int("rst_last_addr", int'(LAST_ADDR), 0);
    check_int("rst_flags", int'({CEF, BEF, BUSY}), 0);
    RST = 1'b0;

    foreach (vecs[v]) begin
      clear_mem();
      mem[0] = vecs[v].w0;
      mem[1] = vecs[v].w1;
      run_list(1'b1);
      check_int({vecs[v].name, "_timeout"}, int'(timed_out), 0);
      check_int({vecs[v].name, "_start_rd"}, start_rd, 1);
      check_int({vecs[v].name, "_start_a"}, start_a, 0);
      check_int({vecs[v].name, "_nreads"}, got_reads.size(), vecs[v].n_reads);
      check_int({vecs[v].name, "_ncmds"}, got_cmds.size(), vecs[v].n_cmds);
      check_int({vecs[v].name, "_last"}, int'(LAST_ADDR), vecs[v].last);
      check_int({vecs[v].name, "_cef"}, int'(CEF), 1);
      if (vecs[v].n_cmds > 0 && got_cmds.size() > 0) begin
        c = got_cmds[0];
        check_int({vecs[v].name, "_cmdctrl"}, int'(c[255:240]), int'(vecs[v].w0));
        check_int({vecs[v].name, "_rdy_to_valid"}, rdy_to_valid, 1);
        check_int({vecs[v].name, "_ack_to_req"}, ack_gap, 2);
      end
    end

    // Stray RDY while idle must not disturb anything.
    @(negedge CLK); VRAM_RDY = 1'b1; VRAM_DI = 16'h0004;
    @(negedge CLK); VRAM_RDY = 1'b0;
    @(negedge CLK);
    check_int("stray_rdy_busy", int'(BUSY), 0);
    check_int("stray_rdy_rd", int'(VRAM_RD), 0);
    check_int("stray_rdy_cef", int'(CEF), 1);

    // Restart: frame 2 begins after END, then START cuts into BODY with a coincident RDY.
    clear_mem();
    mem[0] = 16'h0004; mem[1] = 16'h0000;
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    check_int("restart_bef", int'(BEF), 1);
    check_int("restart_cef", int'(CEF), 0);
    for (int w = 0; w < 5; w++) begin
      VRAM_RDY = 1'b1; VRAM_DI = mem[int'(VRAM_A)];
      @(negedge CLK); VRAM_RDY = 1'b0;
      @(negedge CLK);
    end
    check_int("midbody_addr", int'(VRAM_A), 5);
    START = 1'b1; VRAM_RDY = 1'b1; VRAM_DI = 16'h8000;
    @(negedge CLK); START = 1'b0; VRAM_RDY = 1'b0;
    check_int("midbody_bef", int'(BEF), 0);
    check_int("midbody_cef", int'(CEF), 0);
    check_int("midbody_valid", int'(CMD_VALID), 0);
    check_int("midbody_rd", int'(VRAM_RD), 1);
    check_int("midbody_a", int'(VRAM_A), 0);
    run_list(1'b0);
    check_int("restart_timeout", int'(timed_out), 0);
    check_int("restart_nreads", got_reads.size(), 17);
    check_int("restart_ncmds", got_cmds.size(), 1);
    check_int("restart_last", int'(LAST_ADDR), 'h10);

    // Call then return, then return with empty stack.
    clear_mem();
    mem[0] = 16'h2000; mem[1] = 16'h0100;
    mem['h400] = 16'h3000;
    mem['h10] = 16'h3000;
    run_list(1'b1);
    check_int("callret_timeout", int'(timed_out), 0);
    check_heads("callret", '{0, 'h400, 'h10, 'h20});
    check_int("callret_ncmds", got_cmds.size(), 3);
    check_int("callret_last", int'(LAST_ADDR), 'h20);

    // Wrap: jump to the top table, whose sequential successor wraps to 0.
    clear_mem();
    for (int j = 0; j < 16; j++) mem['h3FFF0 + j] = 16'($urandom);
    mem[0] = 16'h1000; mem[1] = 16'hFFFF;
    mem['h3FFF0] = 16'h0004; mem['h3FFF1] = 16'h0000;
    patch_on = 1'b1; patch_addr = 'h3FFF0;
    run_list(1'b1);
    patch_on = 1'b0;
    check_int("wrap_timeout", int'(timed_out), 0);
    check_heads("wrap", '{0, 'h3FFF0, 0});
    check_int("wrap_ncmds", got_cmds.size(), 2);
    check_int("wrap_last", int'(LAST_ADDR), 0);

    // Random forward-linked chains; returns only go back to call site + 16, so walks end.
    for (int t = 0; t < 20; t++) begin
      clear_mem();
      k = $urandom_range(3, 10);
      for (int s = 0; s < k; s++) begin
        mem[s*16]   = 16'(($urandom_range(0, 7) << 12) | (($urandom & 255) << 4) | $urandom_range(0, 15));
        mem[s*16+1] = 16'($urandom_range(s + 1, k) * 4 + $urandom_range(0, 3));
      end
      model();
      run_list(1'b1);
      check_int("rand_timeout", int'(timed_out), 0);
      check_int("rand_nreads", got_reads.size(), exp_reads.size());
      bad = 0;
      foreach (exp_reads[i])
        if (bad == 0 && i < got_reads.size() && got_reads[i] != exp_reads[i]) begin
          check_int("rand_read_addr", got_reads[i], exp_reads[i]);
          bad = 1;
        end
      check_int("rand_ncmds", got_cmds.size(), exp_cmds.size());
      foreach (exp_cmds[i])
        if (i < got_cmds.size()) begin
          check_cmd("rand_cmd", got_cmds[i], exp_cmds[i]);
          check_int("rand_cmd_addr", got_cmd_addr[i], exp_cmd_addr[i]);
        end
      check_int("rand_last", int'(LAST_ADDR), exp_last);
      check_int("rand_cef", int'(CEF), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
